// File: rtl/vending_pkg.sv
// Shared vending definitions: one-hot coin codes, coin values and the dispenser state type.
// The coin codes are the same encoding the code-to-price lookup decodes.
package vending_pkg;

    localparam logic [3:0] COIN_NONE = 4'b0000;
    localparam logic [3:0] COIN_1    = 4'b0001;
    localparam logic [3:0] COIN_2    = 4'b0010;
    localparam logic [3:0] COIN_5    = 4'b0100;
    localparam logic [3:0] COIN_10   = 4'b1000;

    localparam int VAL_1  = 1;
    localparam int VAL_2  = 2;
    localparam int VAL_5  = 5;
    localparam int VAL_10 = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/coin_select.sv
// Combinational greedy picker: largest coin not exceeding the given amount, as code and value.
// An amount of zero yields no coin (code 0, value 0).
module coin_select
    import vending_pkg::*;
#(
    parameter int AMT_W = 8
) (
    input  logic [AMT_W-1:0] amount,
    output logic [3:0]       code,
    output logic [AMT_W-1:0] value
);

    always_comb begin
        code  = COIN_NONE;
        value = '0;
        if (amount >= AMT_W'(VAL_10)) begin
            code  = COIN_10;
            value = AMT_W'(VAL_10);
        end else if (amount >= AMT_W'(VAL_5)) begin
            code  = COIN_5;
            value = AMT_W'(VAL_5);
        end else if (amount >= AMT_W'(VAL_2)) begin
            code  = COIN_2;
            value = AMT_W'(VAL_2);
        end else if (amount >= AMT_W'(VAL_1)) begin
            code  = COIN_1;
            value = AMT_W'(VAL_1);
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: turns a change amount into a valid/ready stream of one-hot coin codes,
// largest coin first, with busy/done status and a running coin count.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int AMT_W = 8,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AMT_W-1:0] change_amount,
    output logic [3:0]       coin_code,
    output logic             coin_valid,
    input  logic             coin_ready,
    output logic             busy,
    output logic             done,
    output logic [AMT_W-1:0] remaining,
    output logic [CNT_W-1:0] coin_count
);

    state_t           state, state_nx;
    logic [3:0]       code_nx;
    logic             valid_nx, busy_nx, done_nx;
    logic [AMT_W-1:0] rem_nx;
    logic [CNT_W-1:0] cnt_nx;

    // Value of the coin currently offered, kept alongside its code so the
    // post-transfer remainder needs no decode of the one-hot code.
    logic [AMT_W-1:0] coin_val, coin_val_nx;

    logic             xfer;
    logic [AMT_W-1:0] rem_after;
    logic [AMT_W-1:0] sel_in;
    logic [3:0]       sel_code;
    logic [AMT_W-1:0] sel_val;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
    endfunction

    assign xfer      = coin_valid & coin_ready;
    assign rem_after = remaining - coin_val;
    // One picker serves both the initial load and every post-transfer remainder.
    assign sel_in    = (state == IDLE) ? change_amount : rem_after;

    coin_select #(
        .AMT_W (AMT_W)
    ) u_coin_select (
        .amount (sel_in),
        .code   (sel_code),
        .value  (sel_val)
    );

    always_comb begin
        state_nx    = state;
        code_nx     = coin_code;
        valid_nx    = coin_valid;
        busy_nx     = busy;
        done_nx     = (state == DONE);
        rem_nx      = remaining;
        cnt_nx      = coin_count;
        coin_val_nx = coin_val;

        case (state)
            IDLE: begin
                busy_nx = 1'b0;
                if (start) begin
                    cnt_nx = '0;
                    if (change_amount != '0) begin
                        rem_nx      = change_amount;
                        code_nx     = sel_code;
                        coin_val_nx = sel_val;
                        valid_nx    = 1'b1;
                        busy_nx     = 1'b1;
                        state_nx    = EMIT;
                    end else begin
                        rem_nx   = '0;
                        state_nx = DONE;
                    end
                end
            end

            EMIT: begin
                if (xfer) begin
                    rem_nx      = rem_after;
                    cnt_nx      = sat_inc(coin_count);
                    code_nx     = sel_code;
                    coin_val_nx = sel_val;
                    if (rem_after == '0) begin
                        code_nx     = COIN_NONE;
                        coin_val_nx = '0;
                        valid_nx    = 1'b0;
                        busy_nx     = 1'b0;
                        state_nx    = DONE;
                    end
                end
            end

            DONE: begin
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end

            default: begin
                code_nx     = COIN_NONE;
                coin_val_nx = '0;
                valid_nx    = 1'b0;
                busy_nx     = 1'b0;
                state_nx    = IDLE;
            end
        endcase
    end

    // Every output is a flop; done trails the DONE state by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            coin_code  <= COIN_NONE;
            coin_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            remaining  <= '0;
            coin_count <= '0;
            coin_val   <= '0;
        end else begin
            state      <= state_nx;
            coin_code  <= code_nx;
            coin_valid <= valid_nx;
            busy       <= busy_nx;
            done       <= done_nx;
            remaining  <= rem_nx;
            coin_count <= cnt_nx;
            coin_val   <= coin_val_nx;
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: table of directed jobs, reset/abort sequences and random jobs
// scored against a greedy coin-breakdown model computed with integer division.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] change_amount = 8'd0;
    logic [3:0] coin_code;
    logic       coin_valid;
    logic       coin_ready = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] remaining;
    logic [4:0] coin_count;

    int errs = 0;
    int checks = 0;

    logic [3:0] exp_q[$];
    logic [3:0] obs[$];

    change_dispenser #(
        .AMT_W (8),
        .CNT_W (5)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .change_amount (change_amount),
        .coin_code     (coin_code),
        .coin_valid    (coin_valid),
        .coin_ready    (coin_ready),
        .busy          (busy),
        .done          (done),
        .remaining     (remaining),
        .coin_count    (coin_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: count tens, fives, twos, ones by plain division.
    function automatic void build_model(input int amt);
        int r;
        exp_q.delete();
        r = amt;
        repeat (r / 10) exp_q.push_back(4'b1000);
        r = r % 10;
        repeat (r / 5) exp_q.push_back(4'b0100);
        r = r % 5;
        repeat (r / 2) exp_q.push_back(4'b0010);
        r = r % 2;
        repeat (r) exp_q.push_back(4'b0001);
    endfunction

    // rdy: 0..100 = percent chance of ready per cycle; 101 = ready only every 4th cycle.
    task automatic run_job(input logic [7:0] amt, input int rdy, input bit inject,
                           output int done_at, output logic [3:0] first_code,
                           output logic first_valid);
        bit         pv, pr;
        logic [3:0] pc;
        logic [7:0] prem;
        int         n_exp;
        build_model(amt);
        obs.delete();
        @(negedge clk);
        change_amount = amt;
        start = 1'b1;
        coin_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        first_code = coin_code;
        first_valid = coin_valid;
        chk("busy_after_start", busy, (amt != 0));
        done_at = -1;
        pv = 1'b0; pr = 1'b0; pc = 4'd0; prem = 8'd0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (done) begin
                done_at = cyc;
                break;
            end
            if (!coin_valid) chk("code_zero_when_invalid", coin_code, 0);
            if (pv && !pr) begin
                chk("valid_held", coin_valid, 1);
                chk("code_held", coin_code, pc);
                chk("remaining_held", remaining, prem);
            end
            start = inject && (cyc == 1);
            if (start) change_amount = 8'd50;
            if (rdy > 100) coin_ready = ((cyc % 4) == 3);
            else coin_ready = ($urandom_range(99) < rdy);
            if (coin_valid && coin_ready) obs.push_back(coin_code);
            pv = coin_valid; pr = coin_ready; pc = coin_code; prem = remaining;
            @(negedge clk);
        end
        start = 1'b0;
        coin_ready = 1'b0;
        n_exp = exp_q.size();
        chk("done_seen", (done_at >= 0), 1);
        chk("busy_at_done", busy, 0);
        chk("remaining_at_done", remaining, 0);
        chk("coin_count", coin_count, (n_exp > 31) ? 31 : n_exp);
        chk("transfers", obs.size(), n_exp);
        foreach (obs[i]) if (i < n_exp) chk($sformatf("coin[%0d] amt=%0d", i, amt), obs[i], exp_q[i]);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("count_holds", coin_count, (n_exp > 31) ? 31 : n_exp);
    endtask

    typedef struct {
        logic [7:0] amt;
        int         rdy;
        bit         inject;
        int         exp_cnt;
        logic [3:0] exp_first;
        int         exp_done_at;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int         dat;
        logic [3:0] fc;
        logic       fv;
        bit         saw_done;

        vecs[0] = '{8'd18,  100, 1'b0, 4,  4'b1000, 5};
        vecs[1] = '{8'd0,   100, 1'b0, 0,  4'b0000, 1};
        vecs[2] = '{8'd255, 100, 1'b0, 26, 4'b1000, 27};
        vecs[3] = '{8'd7,   101, 1'b0, 2,  4'b0100, -1};
        vecs[4] = '{8'd9,   100, 1'b1, 3,  4'b0100, 4};
        vecs[5] = '{8'd1,   100, 1'b0, 1,  4'b0001, 2};
        vecs[6] = '{8'd4,   100, 1'b0, 2,  4'b0010, 3};
        vecs[7] = '{8'd10,  100, 1'b0, 1,  4'b1000, 2};
        vecs[8] = '{8'd29,  60,  1'b0, 5,  4'b1000, -1};

        repeat (3) @(negedge clk);
        chk("rst_code", coin_code, 0);
        chk("rst_valid", coin_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_remaining", remaining, 0);
        chk("rst_count", coin_count, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vecs[v]) begin
            run_job(vecs[v].amt, vecs[v].rdy, vecs[v].inject, dat, fc, fv);
            chk($sformatf("vec%0d_first_valid", v), fv, (vecs[v].amt != 0));
            chk($sformatf("vec%0d_first_code", v), fc, vecs[v].exp_first);
            chk($sformatf("vec%0d_count", v), obs.size(), vecs[v].exp_cnt);
            if (vecs[v].exp_done_at >= 0)
                chk($sformatf("vec%0d_done_latency", v), dat, vecs[v].exp_done_at);
        end

        // Abort mid-dispense with reset, then confirm a clean restart.
        @(negedge clk);
        change_amount = 8'd23;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        coin_ready = 1'b1;
        @(negedge clk);
        coin_ready = 1'b0;
        chk("abort_pre_remaining", remaining, 13);
        chk("abort_pre_count", coin_count, 1);
        chk("abort_pre_code", coin_code, 4'b1000);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_code", coin_code, 0);
        chk("abort_valid", coin_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_remaining", remaining, 0);
        chk("abort_count", coin_count, 0);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("abort_no_done", saw_done, 0);
        run_job(8'd23, 100, 1'b0, dat, fc, fv);
        chk("restart_first_code", fc, 4'b1000);
        chk("restart_done_latency", dat, 5);

        for (int k = 0; k < 40; k++) begin
            run_job(8'($urandom_range(255)), $urandom_range(100, 20), ($urandom_range(3) == 0),
                    dat, fc, fv);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
